// File: rtl/cordic_sched_if.sv
// Requester-side bus of the shared CORDIC scheduler: packed per-requester
// operands with a one-hot ready, plus the tagged result strobe.
interface cordic_sched_if #(
  parameter int NREQ = 4,
  parameter int IW   = 2,
  parameter int W    = 18
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [W*NREQ-1:0]     req_x;
  logic [W*NREQ-1:0]     req_y;
  logic [(W+1)*NREQ-1:0] req_phase;
  logic                  res_valid;
  logic [IW-1:0]         res_tag;
  logic [1:0]            res_op;
  logic [W-1:0]          res_x;
  logic [W-1:0]          res_y;
  logic [W:0]            res_phase;

  modport master (
    output req_valid, req_op, req_x, req_y, req_phase,
    input  req_ready, res_valid, res_tag, res_op, res_x, res_y, res_phase
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, req_phase,
    output req_ready, res_valid, res_tag, res_op, res_x, res_y, res_phase
  );
endinterface

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined CORDIC among NREQ
// requesters; a tag pipeline matched to the CORDIC latency routes results back.
module cordic_sched #(
  parameter int NREQ = 4,
  parameter int IW   = 2,
  parameter int W    = 18,
  parameter int LAT  = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  cordic_sched_if.slave             bus,
  output logic [1:0]                c_op,
  output logic [W-1:0]              c_x,
  output logic [W-1:0]              c_y,
  output logic [W:0]                c_phase,
  input  logic [W-1:0]              c_xout,
  input  logic [W-1:0]              c_yout,
  input  logic [W:0]                c_pout,
  output logic [$clog2(LAT+2)-1:0]  inflight
);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
    logic [1:0]    op;
  } tag_t;

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] grant_idx;
  logic          grant;
  int            cand;
  logic [1:0]    sel_op;
  logic [W-1:0]  sel_x;
  logic [W-1:0]  sel_y;
  logic [W:0]    sel_phase;
  tag_t          tag_pipe [0:LAT];

  // Search ptr, ptr+1, ... wrapping; ready is gated off in reset and when disabled.
  always_comb begin
    grant         = 1'b0;
    grant_idx     = '0;
    cand          = 0;
    bus.req_ready = '0;
    if (rst_n && en) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NREQ) cand = cand - NREQ;
        if (!grant && bus.req_valid[IW'(cand)]) begin
          grant     = 1'b1;
          grant_idx = IW'(cand);
        end
      end
    end
    if (grant) bus.req_ready = NREQ'(1) << grant_idx;
  end

  always_comb begin
    sel_op    = bus.req_op[2*grant_idx +: 2];
    sel_x     = bus.req_x[W*grant_idx +: W];
    sel_y     = bus.req_y[W*grant_idx +: W];
    sel_phase = bus.req_phase[(W+1)*grant_idx +: (W+1)];
    ptr_next  = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= '0;
      c_op    <= '0;
      c_x     <= '0;
      c_y     <= '0;
      c_phase <= '0;
      for (int s = 0; s <= LAT; s++) tag_pipe[s] <= '0;
    end else begin
      if (grant) begin
        ptr     <= ptr_next;
        c_op    <= sel_op;
        c_x     <= sel_x;
        c_y     <= sel_y;
        c_phase <= sel_phase;
        tag_pipe[0] <= '{valid: 1'b1, idx: grant_idx, op: sel_op};
      end else begin
        c_op    <= '0;
        c_x     <= '0;
        c_y     <= '0;
        c_phase <= '0;
        tag_pipe[0] <= '0;
      end
      for (int s = 1; s <= LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // The last tag stage lines up with the CORDIC output sampled on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_tag   <= '0;
      bus.res_op    <= '0;
      bus.res_x     <= '0;
      bus.res_y     <= '0;
      bus.res_phase <= '0;
      inflight      <= '0;
    end else begin
      bus.res_valid <= tag_pipe[LAT].valid;
      bus.res_tag   <= tag_pipe[LAT].idx;
      bus.res_op    <= tag_pipe[LAT].op;
      bus.res_x     <= c_xout;
      bus.res_y     <= c_yout;
      bus.res_phase <= c_pout;
      if (grant && !tag_pipe[LAT].valid)
        inflight <= inflight + 1'b1;
      else if (!grant && tag_pipe[LAT].valid)
        inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a behavioural fixed-latency CORDIC:
// op 1 is vectoring (gain 1.64676, phase in turns), other ops pass operands through.
module tb_cordic_sched;
  localparam int NREQ = 4;
  localparam int IW   = 2;
  localparam int W    = 18;
  localparam int LAT  = 20;
  localparam int CW   = $clog2(LAT+2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    c_op;
  logic [W-1:0]  c_x, c_y, c_xout, c_yout;
  logic [W:0]    c_phase, c_pout;
  logic [CW-1:0] inflight;

  int compared   = 0;
  int mismatched = 0;

  cordic_sched_if #(.NREQ(NREQ), .IW(IW), .W(W)) bus ();

  cordic_sched #(.NREQ(NREQ), .IW(IW), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus),
    .c_op(c_op), .c_x(c_x), .c_y(c_y), .c_phase(c_phase),
    .c_xout(c_xout), .c_yout(c_yout), .c_pout(c_pout),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] vec_mag(input logic [W-1:0] x, input logic [W-1:0] y);
    real rx, ry;
    rx = $itor($signed(x));
    ry = $itor($signed(y));
    return W'($rtoi($sqrt(rx*rx + ry*ry) * 1.646760258 + 0.5));
  endfunction

  function automatic logic [W:0] vec_ang(input logic [W-1:0] x, input logic [W-1:0] y);
    real a;
    a = $atan2($itor($signed(y)), $itor($signed(x)));
    return (W+1)'($rtoi(a / (2.0 * 3.14159265358979) * 524288.0 + 0.5));
  endfunction

  logic [W-1:0] mx [LAT];
  logic [W-1:0] my [LAT];
  logic [W:0]   mp [LAT];

  // Free-running CORDIC model: never stalls, not reset, output LAT edges after input.
  always @(posedge clk) begin
    if (c_op == 2'd1) begin
      mx[0] <= vec_mag(c_x, c_y);
      my[0] <= '0;
      mp[0] <= vec_ang(c_x, c_y);
    end else begin
      mx[0] <= c_x;
      my[0] <= c_y;
      mp[0] <= c_phase;
    end
    for (int s = 1; s < LAT; s++) begin
      mx[s] <= mx[s-1];
      my[s] <= my[s-1];
      mp[s] <= mp[s-1];
    end
  end

  assign c_xout = mx[LAT-1];
  assign c_yout = my[LAT-1];
  assign c_pout = mp[LAT-1];

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic check_near(input string name, input int obs, input int exp, input int tol);
    compared++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d +/- %0d", name, obs, exp, tol);
    end
  endtask

  task automatic apply_stimulus(input int i, input logic [1:0] op, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic [W:0] ph);
    bus.req_op[2*i +: 2]            = op;
    bus.req_x[W*i +: W]             = x;
    bus.req_y[W*i +: W]             = y;
    bus.req_phase[(W+1)*i +: (W+1)] = ph;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int seen, nres, infl20, infl_seen, peak, late;
  int rc [16];
  logic [IW-1:0] rtag [16];
  logic [W-1:0]  rx [16];
  logic [1:0]    rop;
  logic [W-1:0]  ry1;
  logic [W:0]    rph;

  initial begin
    rst_n         = 1'b0;
    en            = 1'b1;
    bus.req_valid = '1;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_phase = '0;
    tick();
    tick();
    #1;
    check_output("rst_ready", bus.req_ready, 0);
    check_output("rst_res_valid", bus.res_valid, 0);
    check_output("rst_inflight", inflight, 0);
    check_output("rst_c_x", c_x, 0);

    // Single op from requester 0: result exactly LAT+1 edges after acceptance.
    bus.req_valid = '0;
    rst_n = 1'b1;
    apply_stimulus(0, 2'd0, 18'd13568, 18'd0, 19'd0);
    bus.req_valid = 4'b0001;
    #1;
    check_output("t1_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    check_output("t1_c_x", c_x, 13568);
    check_output("t1_inflight_issue", inflight, 1);
    seen = 0; nres = 0; infl20 = -1; infl_seen = -1;
    rtag[0] = '0; rx[0] = '0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (n == 1) check_output("t1_c_x_idle", c_x, 0);
      if (n == 20) infl20 = int'(inflight);
      if (bus.res_valid) begin
        nres++;
        if (seen == 0) begin
          seen = n; rtag[0] = bus.res_tag; rx[0] = bus.res_x; infl_seen = int'(inflight);
        end
      end
    end
    check_output("t1_latency", seen, 21);
    check_output("t1_count", nres, 1);
    check_output("t1_tag", rtag[0], 0);
    check_output("t1_res_x", rx[0], 13568);
    check_output("t1_inflight_before", infl20, 1);
    check_output("t1_inflight_after", infl_seen, 0);

    // All four requesters valid for 12 cycles.
    do_reset();
    for (int i = 0; i < NREQ; i++) apply_stimulus(i, (i >= 2) ? 2'(i) : 2'd0, W'(1000 + i), 18'd0, 19'd0);
    nres = 0; peak = 0;
    for (int c = 0; c < 50; c++) begin
      bus.req_valid = (c < 12) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 12) check_output($sformatf("t2_ready_%0d", c), bus.req_ready, 4'b0001 << (c % 4));
      tick();
      if (int'(inflight) > peak) peak = int'(inflight);
      if (bus.res_valid && nres < 16) begin
        rc[nres] = c; rtag[nres] = bus.res_tag; rx[nres] = bus.res_x;
        if (nres == 2) rop = bus.res_op;
        nres++;
      end
    end
    check_output("t2_count", nres, 12);
    for (int j = 0; j < 12; j++) begin
      check_output($sformatf("t2_tag_%0d", j), rtag[j], j % 4);
      check_output($sformatf("t2_x_%0d", j), rx[j], 1000 + (j % 4));
      check_output($sformatf("t2_when_%0d", j), rc[j], 21 + j);
    end
    check_output("t2_op_echo", rop, 2);
    check_output("t2_peak", peak, 12);
    check_output("t2_drained", inflight, 0);

    // Sparse valids: round-robin skips idle requesters without bubbles.
    do_reset();
    bus.req_valid = 4'b1010;
    #1; check_output("t3_g1", bus.req_ready, 4'b0010);
    tick();
    #1; check_output("t3_g3", bus.req_ready, 4'b1000);
    tick();
    #1; check_output("t3_g1b", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'b0011;
    #1; check_output("t3_g0", bus.req_ready, 4'b0001);
    tick();
    #1; check_output("t3_g1c", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    check_output("t3_inflight", inflight, 5);
    for (int n = 0; n < 25; n++) tick();

    // Stream on requester 2 with en low for cycles 5..9.
    do_reset();
    apply_stimulus(2, 2'd0, 18'd777, 18'd5, 19'd9);
    nres = 0;
    for (int c = 0; c < 50; c++) begin
      bus.req_valid = (c < 15) ? 4'b0100 : 4'b0000;
      en = !(c >= 5 && c <= 9);
      #1;
      if (c < 15) check_output($sformatf("t4_ready_%0d", c), bus.req_ready, en ? 4'b0100 : 4'b0000);
      tick();
      if (bus.res_valid && nres < 16) begin
        rc[nres] = c; rtag[nres] = bus.res_tag; nres++;
      end
    end
    en = 1'b1;
    check_output("t4_count", nres, 10);
    for (int j = 0; j < 10; j++)
      check_output($sformatf("t4_when_%0d", j), rc[j], (j < 5) ? 21 + j : 26 + j);
    check_output("t4_tag", rtag[7], 2);

    // Reset mid-flight drops every outstanding op.
    do_reset();
    apply_stimulus(0, 2'd0, 18'd42, 18'd0, 19'd0);
    late = 0;
    for (int c = 0; c < 46; c++) begin
      bus.req_valid = (c < 6 || c == 10) ? 4'b0001 : 4'b0000;
      rst_n = (c != 10);
      #1;
      if (c == 9) check_output("t5_inflight_pre", inflight, 6);
      if (c == 10) check_output("t5_ready_in_reset", bus.req_ready, 0);
      tick();
      if (c == 10) check_output("t5_inflight_reset", inflight, 0);
      if (c >= 10 && bus.res_valid) late++;
    end
    check_output("t5_no_results", late, 0);
    check_output("t5_inflight_end", inflight, 0);

    // Vectoring op: magnitude gain and +1/8 turn.
    do_reset();
    apply_stimulus(0, 2'd1, 18'd10000, 18'd10000, 19'd0);
    bus.req_valid = 4'b0001;
    #1;
    tick();
    bus.req_valid = '0;
    seen = 0; rx[0] = '0; ry1 = '0; rph = '0; rop = '0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.res_valid && seen == 0) begin
        seen = n; rx[0] = bus.res_x; ry1 = bus.res_y; rph = bus.res_phase; rop = bus.res_op;
      end
    end
    check_output("t6_latency", seen, 21);
    check_output("t6_op", rop, 1);
    check_near("t6_mag", int'($signed(rx[0])), 23288, 4);
    check_near("t6_y", int'($signed(ry1)), 0, 4);
    check_near("t6_phase", int'($signed(rph)), 65536, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
